// File: rtl/mem_wb_pipe_pkg.sv
// Shared definitions for the MEM->WB pipeline slice: bus types, access sizes
// and the per-lane writeback record.
package mem_wb_pipe_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] word_t;
    typedef logic [4:0]  regidx_t;

    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2
    } msize_t;

    typedef struct packed {
        logic  data_ok;
        word_t data;
    } dbus_resp_t;

    typedef struct packed {
        logic    valid;
        addr_t   pc;
        logic    reg_write;
        regidx_t write_reg;
        word_t   alu_out;
    } wb_lane_t;

endpackage

// File: rtl/mem_wb_pipe_load_align.sv
// Combinational load alignment: picks the addressed byte/halfword out of a
// raw bus word and sign- or zero-extends it to a full word.
module load_align
    import mem_wb_pipe_pkg::*;
(
    input  word_t      word,
    input  logic [1:0] addr,
    input  msize_t     size,
    input  logic       sext,
    output word_t      result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[{addr, 3'b000} +: 8];
        half_sel = word[{addr[1], 4'b0000} +: 16];
        result   = word;
        unique case (size)
            MSIZE1:  result = {{24{sext & byte_sel[7]}}, byte_sel};
            MSIZE2:  result = {{16{sext & half_sel[15]}}, half_sel};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/mem_wb_pipe.sv
// MEM->WB pipeline register with per-lane valids, a one-entry hold buffer for
// data-bus responses that arrive during a writeback stall, and lane 0 load alignment.
module mem_wb_pipe
    import mem_wb_pipe_pkg::*;
#(
    parameter int unsigned LANES = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             stall_w,
    input  logic             flush_w,
    input  logic [LANES-1:0] m_valid,
    input  addr_t            m_pc        [LANES],
    input  logic [LANES-1:0] m_reg_write,
    input  regidx_t          m_write_reg [LANES],
    input  word_t            m_alu_out   [LANES],
    input  logic             m_mem_to_reg,
    input  msize_t           m_size,
    input  logic             m_signed,
    input  dbus_resp_t       dresp,
    output logic [LANES-1:0] w_valid,
    output addr_t            w_pc        [LANES],
    output logic [LANES-1:0] w_reg_write,
    output regidx_t          w_write_reg [LANES],
    output word_t            w_result    [LANES],
    output logic             w_mem_to_reg,
    output logic             dresp_held
);

    wb_lane_t [LANES-1:0] w_lane;
    msize_t               w_size;
    logic                 w_signed;
    word_t                w_raw;
    logic                 hold_valid;
    word_t                hold_data;
    word_t                load_value;

    always_ff @(posedge clk) begin
        if (!resetn || flush_w) begin
            w_lane       <= '0;
            w_mem_to_reg <= 1'b0;
            w_size       <= MSIZE4;
            w_signed     <= 1'b0;
            w_raw        <= '0;
            hold_valid   <= 1'b0;
            hold_data    <= '0;
        end else if (stall_w) begin
            // First response of a stall wins; later data_ok pulses are protocol errors.
            if (dresp.data_ok && !hold_valid) begin
                hold_valid <= 1'b1;
                hold_data  <= dresp.data;
            end
        end else begin
            for (int unsigned i = 0; i < LANES; i++) begin
                w_lane[i].valid     <= m_valid[i];
                w_lane[i].pc        <= m_pc[i];
                w_lane[i].reg_write <= m_reg_write[i];
                w_lane[i].write_reg <= m_write_reg[i];
                w_lane[i].alu_out   <= m_alu_out[i];
            end
            w_mem_to_reg <= m_mem_to_reg;
            w_size       <= m_size;
            w_signed     <= m_signed;
            w_raw        <= hold_valid ? hold_data : dresp.data;
            hold_valid   <= 1'b0;
        end
    end

    load_align u_load_align (
        .word   (w_raw),
        .addr   (w_lane[0].alu_out[1:0]),
        .size   (w_size),
        .sext   (w_signed),
        .result (load_value)
    );

    always_comb begin
        for (int unsigned i = 0; i < LANES; i++) begin
            w_valid[i]     = w_lane[i].valid;
            w_pc[i]        = w_lane[i].pc;
            w_reg_write[i] = w_lane[i].reg_write & w_lane[i].valid;
            w_write_reg[i] = w_lane[i].write_reg;
            w_result[i]    = w_lane[i].alu_out;
        end
        if (w_mem_to_reg) begin
            w_result[0] = load_value;
        end
    end

    assign dresp_held = hold_valid;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Directed self-checking bench for mem_wb_pipe (dual-lane build) with
// hand-computed expected values.
module tb_mem_wb_pipe;
    import mem_wb_pipe_pkg::*;

    localparam int unsigned LANES = 2;

    logic             clk;
    logic             resetn;
    logic             stall_w;
    logic             flush_w;
    logic [LANES-1:0] m_valid;
    addr_t            m_pc        [LANES];
    logic [LANES-1:0] m_reg_write;
    regidx_t          m_write_reg [LANES];
    word_t            m_alu_out   [LANES];
    logic             m_mem_to_reg;
    msize_t           m_size;
    logic             m_signed;
    dbus_resp_t       dresp;
    logic [LANES-1:0] w_valid;
    addr_t            w_pc        [LANES];
    logic [LANES-1:0] w_reg_write;
    regidx_t          w_write_reg [LANES];
    word_t            w_result    [LANES];
    logic             w_mem_to_reg;
    logic             dresp_held;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    mem_wb_pipe #(.LANES(LANES)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .stall_w      (stall_w),
        .flush_w      (flush_w),
        .m_valid      (m_valid),
        .m_pc         (m_pc),
        .m_reg_write  (m_reg_write),
        .m_write_reg  (m_write_reg),
        .m_alu_out    (m_alu_out),
        .m_mem_to_reg (m_mem_to_reg),
        .m_size       (m_size),
        .m_signed     (m_signed),
        .dresp        (dresp),
        .w_valid      (w_valid),
        .w_pc         (w_pc),
        .w_reg_write  (w_reg_write),
        .w_write_reg  (w_write_reg),
        .w_result     (w_result),
        .w_mem_to_reg (w_mem_to_reg),
        .dresp_held   (dresp_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One clock; outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_load(input addr_t addr, input msize_t size, input logic sext);
        m_valid      = 2'b01;
        m_reg_write  = 2'b01;
        m_pc[0]      = 32'h0000_0400;
        m_write_reg[0] = 5'd5;
        m_alu_out[0] = addr;
        m_mem_to_reg = 1'b1;
        m_size       = size;
        m_signed     = sext;
    endtask

    task automatic set_resp(input logic ok, input word_t data);
        dresp.data_ok = ok;
        dresp.data    = data;
    endtask

    initial begin
        resetn = 1'b0; stall_w = 1'b0; flush_w = 1'b0;
        m_valid = '0; m_reg_write = '0; m_mem_to_reg = 1'b0;
        m_size = MSIZE4; m_signed = 1'b0;
        for (int i = 0; i < int'(LANES); i++) begin
            m_pc[i] = '0; m_write_reg[i] = '0; m_alu_out[i] = '0;
        end
        set_resp(1'b0, '0);
        step();
        step();

        // Reset state
        check("rst_valid", 32'(w_valid), 32'h0);
        check("rst_regwr", 32'(w_reg_write), 32'h0);
        check("rst_res0", w_result[0], 32'h0);
        check("rst_res1", w_result[1], 32'h0);
        check("rst_held", 32'(dresp_held), 32'h0);

        // Signed byte load at offset 2, response used directly
        resetn = 1'b1;
        set_load(32'h0000_1002, MSIZE1, 1'b1);
        set_resp(1'b1, 32'h1280_5678);
        step();
        check("sb_res", w_result[0], 32'hFFFF_FF80);
        check("sb_valid", 32'(w_valid), 32'h1);
        check("sb_regwr", 32'(w_reg_write), 32'h1);
        check("sb_dst", 32'(w_write_reg[0]), 32'd5);
        check("sb_m2r", 32'(w_mem_to_reg), 32'h1);
        check("sb_pc", w_pc[0], 32'h0000_0400);
        check("sb_noheld", 32'(dresp_held), 32'h0);

        set_load(32'h0000_1002, MSIZE1, 1'b0);
        step();
        check("ub_res", w_result[0], 32'h0000_0080);
        set_load(32'h0000_1003, MSIZE1, 1'b1);
        step();
        check("sb3_res", w_result[0], 32'h0000_0012);
        set_load(32'h0000_1000, MSIZE1, 1'b0);
        step();
        check("ub0_res", w_result[0], 32'h0000_0078);

        // Unsigned halfword held across a 3-cycle stall
        set_load(32'h0000_2002, MSIZE2, 1'b0);
        stall_w = 1'b1;
        set_resp(1'b1, 32'hABCD_1234);
        step();
        check("st_held1", 32'(dresp_held), 32'h1);
        check("st_hold_res", w_result[0], 32'h0000_0078);
        set_resp(1'b0, 32'hDEAD_BEEF);
        step();
        step();
        check("st_held3", 32'(dresp_held), 32'h1);
        stall_w = 1'b0;
        step();
        check("uh_res", w_result[0], 32'h0000_ABCD);
        check("uh_held", 32'(dresp_held), 32'h0);

        // Signed halfword upper, then low halfword with addr[0] ignored
        set_load(32'h0000_2002, MSIZE2, 1'b1);
        set_resp(1'b1, 32'hABCD_1234);
        step();
        check("sh_res", w_result[0], 32'hFFFF_ABCD);
        set_load(32'h0000_2001, MSIZE2, 1'b1);
        step();
        check("sh_lo_res", w_result[0], 32'h0000_1234);

        // Flush beats stall and drops the held response
        set_load(32'h0000_3000, MSIZE4, 1'b0);
        stall_w = 1'b1;
        set_resp(1'b1, 32'h0000_0099);
        step();
        check("fl_pre_held", 32'(dresp_held), 32'h1);
        flush_w = 1'b1;
        step();
        check("fl_valid", 32'(w_valid), 32'h0);
        check("fl_regwr", 32'(w_reg_write), 32'h0);
        check("fl_res0", w_result[0], 32'h0);
        check("fl_m2r", 32'(w_mem_to_reg), 32'h0);
        check("fl_pc", w_pc[0], 32'h0);
        check("fl_dst", 32'(w_write_reg[0]), 32'h0);
        check("fl_held", 32'(dresp_held), 32'h0);
        flush_w = 1'b0;
        stall_w = 1'b0;

        // Dual issue ALU ops
        set_resp(1'b0, '0);
        m_valid = 2'b11; m_reg_write = 2'b11; m_mem_to_reg = 1'b0;
        m_pc[0] = 32'h0000_0500; m_pc[1] = 32'h0000_0504;
        m_write_reg[0] = 5'd4; m_write_reg[1] = 5'd3;
        m_alu_out[0] = 32'h66; m_alu_out[1] = 32'h55;
        step();
        check("dual_valid", 32'(w_valid), 32'h3);
        check("dual_regwr", 32'(w_reg_write), 32'h3);
        check("dual_res0", w_result[0], 32'h66);
        check("dual_res1", w_result[1], 32'h55);
        check("dual_dst0", 32'(w_write_reg[0]), 32'd4);
        check("dual_dst1", 32'(w_write_reg[1]), 32'd3);
        check("dual_pc1", w_pc[1], 32'h0000_0504);
        m_valid = 2'b01;
        step();
        check("inv1_valid", 32'(w_valid), 32'h1);
        check("inv1_regwr", 32'(w_reg_write), 32'h1);
        check("inv1_res1", w_result[1], 32'h55);

        // Second data_ok in one stall is ignored
        set_load(32'h0000_3000, MSIZE4, 1'b0);
        stall_w = 1'b1;
        set_resp(1'b1, 32'h0000_0001);
        step();
        set_resp(1'b1, 32'h0000_0002);
        step();
        set_resp(1'b0, 32'h0000_0003);
        stall_w = 1'b0;
        step();
        check("dup_res", w_result[0], 32'h0000_0001);

        // Reset during a stall discards held data
        stall_w = 1'b1;
        set_resp(1'b1, 32'h0000_0077);
        step();
        check("rs_pre_held", 32'(dresp_held), 32'h1);
        resetn = 1'b0;
        step();
        check("rs_held", 32'(dresp_held), 32'h0);
        check("rs_valid", 32'(w_valid), 32'h0);
        resetn = 1'b1;
        stall_w = 1'b0;
        set_resp(1'b0, 32'h0000_5A5A);
        step();
        check("rs_res", w_result[0], 32'h0000_5A5A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
